// File: rtl/pingpong_pkg.sv
// Shared types, constants and helpers for the ping-pong RAM.
package pingpong_pkg;

    // One bit selects which of the two banks is meant
    typedef logic bank_sel_t;

    localparam int NBANKS = 2;

    // Byte-lane count for a given data width
    function automatic int bw_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One bank of the ping-pong RAM: 2**AW x DW array with an active-low
// byte-lane write port and a registered read port.
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 3,
    parameter int BW = bw_of(DW)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] di,
    input  logic [BW-1:0] be_n,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    // Write only the lanes whose enable is low; the rest keep their contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BW; i++) begin
                if (!be_n[i]) begin
                    mem[wa][i*8 +: 8] <= di[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; q holds its last value when re is low
    always_ff @(posedge clk) begin
        if (re) begin
            q <= mem[ra];
        end
    end

endmodule

// File: rtl/pingpong_ram.sv
// Ping-pong (double-buffered) RAM with commit/release ownership handshake.
// Optional macro PINGPONG_OUTREG_EN adds an output register (read latency 2).
module pingpong_ram
    import pingpong_pkg::*;
#(
    parameter  int DW = 64,
    parameter  int AW = 3,
    localparam int BW = bw_of(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] di,
    input  logic [BW-1:0] be_n,
    input  logic          wr_commit,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] ra,
    input  logic          rd_release,
    output logic          rd_avail,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          wr_ovf
);

    bank_sel_t     wsel_reg, wsel_next;
    bank_sel_t     rsel;
    logic [1:0]    full_reg, full_next;
    logic          wr_acc, commit_acc, release_acc;
    logic          wr_ovf_reg;

    bank_sel_t     rd_sel_reg;
    logic          dout_zero_reg;
    logic          dout_valid_reg;
    logic [DW-1:0] bank_q [NBANKS];
    logic [DW-1:0] dout_s1;

    assign rsel     = ~wsel_reg;
    assign wr_ready = ~full_reg[wsel_reg];
    assign rd_avail = full_reg[rsel];
    assign wr_ovf   = wr_ovf_reg;

    // Ownership update: apply commit and release, then swap if the write bank
    // is full while the read bank is empty
    always_comb begin
        wr_acc      = wr_en && wr_ready;
        commit_acc  = wr_commit && wr_ready;
        release_acc = rd_release && rd_avail;
        full_next   = full_reg;
        if (commit_acc) begin
            full_next[wsel_reg] = 1'b1;
        end
        if (release_acc) begin
            full_next[rsel] = 1'b0;
        end
        wsel_next = wsel_reg;
        if (full_next[wsel_reg] && !full_next[rsel]) begin
            wsel_next = ~wsel_reg;
        end
    end

    // Control and first read-stage bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wsel_reg       <= 1'b0;
            full_reg       <= 2'b00;
            wr_ovf_reg     <= 1'b0;
            rd_sel_reg     <= 1'b0;
            dout_zero_reg  <= 1'b1;
            dout_valid_reg <= 1'b0;
        end else begin
            wsel_reg <= wsel_next;
            full_reg <= full_next;
            if ((wr_en || wr_commit) && !wr_ready) begin
                wr_ovf_reg <= 1'b1;
            end
            if (rd_en) begin
                rd_sel_reg    <= rsel;
                dout_zero_reg <= 1'b0;
            end
            dout_valid_reg <= rd_en && rd_avail;
        end
    end

    generate
        for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
            pingpong_bank #(
                .DW (DW),
                .AW (AW),
                .BW (BW)
            ) u_bank (
                .clk  (clk),
                .we   (wr_acc && (wsel_reg == bank_sel_t'(gi))),
                .wa   (wa),
                .di   (di),
                .be_n (be_n),
                .re   (rd_en && (rsel == bank_sel_t'(gi))),
                .ra   (ra),
                .q    (bank_q[gi])
            );
        end
    endgenerate

    // Bank outputs are not reset, so dout reads as zero until the first read
    assign dout_s1 = dout_zero_reg ? '0 : bank_q[rd_sel_reg];

`ifdef PINGPONG_OUTREG_EN
    logic [DW-1:0] dout_reg;
    logic          dout_valid_out_reg;

    // Second read stage: data and valid move together
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg           <= '0;
            dout_valid_out_reg <= 1'b0;
        end else begin
            dout_reg           <= dout_s1;
            dout_valid_out_reg <= dout_valid_reg;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_out_reg;
`else
    assign dout       = dout_s1;
    assign dout_valid = dout_valid_reg;
`endif

endmodule

// File: tb/tb_pingpong_ram.sv
// Scoreboard bench for pingpong_ram: reads push expected responses, a
// monitor pops and compares them when they fall due.
module tb_pingpong_ram;

`ifdef PINGPONG_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [63:0] BASE = 64'h1234_5678_9abc_def0;
    localparam logic [63:0] DA0  = 64'hA0A0_A0A0_0000_1111;
    localparam logic [63:0] DB0  = 64'hB0B0_B0B0_2222_3333;
    localparam logic [63:0] DC1  = 64'hC1C1_C1C1_4444_5555;
    localparam logic [63:0] DBAD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wa;
    logic [63:0] di;
    logic [7:0]  be_n;
    logic        wr_commit;
    logic        wr_ready;
    logic        rd_en;
    logic [2:0]  ra;
    logic        rd_release;
    logic        rd_avail;
    logic [63:0] dout;
    logic        dout_valid;
    logic        wr_ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic        valid;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    pingpong_ram #(.DW(64), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wa         (wa),
        .di         (di),
        .be_n       (be_n),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready),
        .rd_en      (rd_en),
        .ra         (ra),
        .rd_release (rd_release),
        .rd_avail   (rd_avail),
        .dout       (dout),
        .dout_valid (dout_valid),
        .wr_ovf     (wr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Monitor: compare a due response, and flag any unexpected valid output
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rd_valid", {63'd0, dout_valid}, {63'd0, e.valid});
            if (e.valid) begin
                check("rd_data", dout, e.data);
            end
        end else if (dout_valid) begin
            check("spurious_valid", {63'd0, dout_valid}, 64'd0);
        end
    end

    task automatic push_rd(input logic v, input logic [63:0] d);
        exp_t e;
        e.due   = cyc + LAT;
        e.valid = v;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        wr_commit  = 1'b0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        be_n       = 8'hFF;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            step();
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wa = 0; di = 0; be_n = 8'hFF; wr_commit = 0;
        rd_en = 0; ra = 0; rd_release = 0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_wr_ready",   {63'd0, wr_ready},   64'd1);
        check("rst_rd_avail",   {63'd0, rd_avail},   64'd0);
        check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
        check("rst_wr_ovf",     {63'd0, wr_ovf},     64'd0);
        check("rst_dout",       dout,                64'd0);

        // Fill bank0, commit on the last write, then drain it
        for (int a = 0; a < 8; a++) begin
            check("fill_wr_ready", {63'd0, wr_ready}, 64'd1);
            wr_en = 1; wa = 3'(a); di = BASE + 64'(a); be_n = 8'h00;
            wr_commit = (a == 7);
            step();
        end
        check("fill_rd_avail", {63'd0, rd_avail}, 64'd1);
        check("fill_wr_ready_post", {63'd0, wr_ready}, 64'd1);
        for (int a = 0; a < 8; a++) begin
            rd_en = 1; ra = 3'(a);
            push_rd(1'b1, BASE + 64'(a));
            step();
        end
        rd_release = 1;
        step();
        check("rel_rd_avail", {63'd0, rd_avail}, 64'd0);
        drain();

        // Byte enables on bank1 address 3
        wr_en = 1; wa = 3; di = 64'hFFFF_FFFF_FFFF_FFFF; be_n = 8'h00;
        step();
        wr_en = 1; wa = 3; di = 64'h0; be_n = 8'h0F;
        step();
        wr_commit = 1;
        step();
        check("be_rd_avail", {63'd0, rd_avail}, 64'd1);
        rd_en = 1; ra = 3;
        push_rd(1'b1, 64'h0000_0000_FFFF_FFFF);
        step();
        rd_release = 1;
        step();
        drain();

        // Stall and overflow: both banks committed without release
        wr_en = 1; wa = 0; di = DA0; be_n = 8'h00; wr_commit = 1;
        step();
        check("stall_first_ready", {63'd0, wr_ready}, 64'd1);
        wr_en = 1; wa = 0; di = DB0; be_n = 8'h00; wr_commit = 1;
        step();
        check("stall_wr_ready", {63'd0, wr_ready}, 64'd0);
        check("stall_rd_avail", {63'd0, rd_avail}, 64'd1);
        wr_en = 1; wa = 0; di = DBAD; be_n = 8'h00;
        step();
        check("ovf_set",        {63'd0, wr_ovf},   64'd1);
        check("ovf_wr_ready",   {63'd0, wr_ready}, 64'd0);
        rd_en = 1; ra = 0; push_rd(1'b1, DA0);
        step();
        // Release while reading the released bank
        rd_en = 1; ra = 0; push_rd(1'b1, DA0); rd_release = 1;
        step();
        check("swap_wr_ready", {63'd0, wr_ready}, 64'd1);
        check("swap_rd_avail", {63'd0, rd_avail}, 64'd1);
        rd_en = 1; ra = 0; push_rd(1'b1, DB0);
        step();
        check("ovf_sticky", {63'd0, wr_ovf}, 64'd1);

        // Simultaneous write+commit, release and read in one cycle
        wr_en = 1; wa = 1; di = DC1; be_n = 8'h00; wr_commit = 1;
        rd_release = 1; rd_en = 1; ra = 0; push_rd(1'b1, DB0);
        step();
        check("simul_wr_ready", {63'd0, wr_ready}, 64'd1);
        check("simul_rd_avail", {63'd0, rd_avail}, 64'd1);
        rd_en = 1; ra = 1; push_rd(1'b1, DC1);
        step();
        drain();

        // Reset mid-fill
        for (int a = 0; a < 4; a++) begin
            wr_en = 1; wa = 3'(a); di = 64'(a); be_n = 8'h00;
            step();
        end
        rst = 1;
        step();
        rst = 0;
        check("mid_rst_wr_ready",   {63'd0, wr_ready},   64'd1);
        check("mid_rst_rd_avail",   {63'd0, rd_avail},   64'd0);
        check("mid_rst_dout_valid", {63'd0, dout_valid}, 64'd0);
        check("mid_rst_wr_ovf",     {63'd0, wr_ovf},     64'd0);
        check("mid_rst_dout",       dout,                64'd0);
        rd_en = 1; ra = 0; push_rd(1'b0, 64'd0);
        step();
        drain();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
